// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writable program memory for the picoMIPS core, filled after reset
// by a little-endian byte-stream loader and then served as registered instruction fetches.
//
// Optional build macro: PROG_LOAD_CHECKSUM_EN
//   When defined, the load is followed by one checksum word (XOR of all loaded words).
//   A match enters RUN; a mismatch enters a sticky ERROR state (left by reset or reload).
//   When undefined, the load completes straight to RUN and err is tied low.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   n_reset    synchronous active-low reset
//   ld_data    loader byte
//   ld_valid   loader byte present
//   ld_ready   loader byte accepted this cycle (LOAD / CHECK)
//   ld_last    final byte of the program (qualified by ld_valid && ld_ready)
//   reload     single-cycle request to re-enter LOAD from RUN / ERROR
//   address    fetch address from the core PC
//   I          fetched instruction, registered
//   i_valid    I holds data for the previous cycle's address
//   cpu_en     core may advance (RUN only)
//   load_count words written in the current load
//   err        checksum mismatch, sticky until reset / reload
module prog_mem_loader #(
    parameter int unsigned     Psize         = 5,
    parameter int unsigned     Isize         = 15,
    parameter int unsigned     Bsize         = 8,
    parameter logic [Isize-1:0] DEFAULT_INSTR = 15'b100_00_00_00000000
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [Bsize-1:0] ld_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_last,
    input  logic             reload,
    input  logic [Psize-1:0] address,
    output logic [Isize-1:0] I,
    output logic             i_valid,
    output logic             cpu_en,
    output logic [Psize:0]   load_count,
    output logic             err
);

    localparam int unsigned Depth = 1 << Psize;
    localparam int unsigned BPW   = (Isize + Bsize - 1) / Bsize;
    localparam int unsigned IdxW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned BufW  = BPW * Bsize;

`ifdef PROG_LOAD_CHECKSUM_EN
    typedef enum logic [1:0] {StLoad, StRun, StCheck, StError} state_e;
`else
    typedef enum logic [1:0] {StLoad, StRun} state_e;
`endif

    state_e             state_q, state_d;
    logic [Psize-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0]    byte_idx_q, byte_idx_d;
    logic [BufW-1:0]    word_buf_q, word_buf_d;
    logic [Depth-1:0]   valid_q, valid_d;
    logic [Psize:0]     load_count_q, load_count_d;
    logic [Isize-1:0]   instr_q, instr_d;
    logic               i_valid_q, i_valid_d;
`ifdef PROG_LOAD_CHECKSUM_EN
    logic [Isize-1:0]   csum_q, csum_d;
    logic               err_q, err_d;
`endif

    logic [Isize-1:0]   mem [Depth];
    logic               mem_we;
    logic               xfer;
    logic               last_byte;
    logic [BufW-1:0]    word_asm;
    logic [Isize-1:0]   new_word;
    logic [Isize-1:0]   fetch_word;

    // Current byte merged into the partial word. The buffer is cleared after every
    // word write, so upper bytes not yet received are already zero (ld_last padding).
    always_comb begin
        word_asm = word_buf_q;
        for (int k = 0; k < BPW; k++) begin
            if (IdxW'(k) == byte_idx_q) begin
                word_asm[k*Bsize +: Bsize] = ld_data;
            end
        end
    end

    assign new_word   = word_asm[Isize-1:0];
    assign last_byte  = (byte_idx_q == IdxW'(BPW - 1));
    assign xfer       = ld_valid && ld_ready;
    assign fetch_word = valid_q[address] ? mem[address] : DEFAULT_INSTR;

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        byte_idx_d   = byte_idx_q;
        word_buf_d   = word_buf_q;
        valid_d      = valid_q;
        load_count_d = load_count_q;
        instr_d      = DEFAULT_INSTR;
        i_valid_d    = 1'b0;
        mem_we       = 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif

        unique case (state_q)
            StLoad: begin
                if (xfer) begin
                    if (last_byte || ld_last) begin
                        mem_we           = 1'b1;
                        valid_d[wr_ptr_q] = 1'b1;
                        wr_ptr_d         = wr_ptr_q + 1'b1;
                        load_count_d     = load_count_q + 1'b1;
                        byte_idx_d       = '0;
                        word_buf_d       = '0;
`ifdef PROG_LOAD_CHECKSUM_EN
                        csum_d           = csum_q ^ new_word;
`endif
                        if (ld_last || (wr_ptr_q == {Psize{1'b1}})) begin
`ifdef PROG_LOAD_CHECKSUM_EN
                            state_d = StCheck;
`else
                            state_d = StRun;
`endif
                        end
                    end else begin
                        word_buf_d = word_asm;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end

`ifdef PROG_LOAD_CHECKSUM_EN
            // Checksum word always takes BPW bytes; ld_last has no meaning here.
            StCheck: begin
                if (xfer) begin
                    if (last_byte) begin
                        byte_idx_d = '0;
                        word_buf_d = '0;
                        if (new_word == csum_q) begin
                            state_d = StRun;
                        end else begin
                            state_d = StError;
                            err_d   = 1'b1;
                        end
                    end else begin
                        word_buf_d = word_asm;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end

            StError: begin
                if (reload) begin
                    state_d      = StLoad;
                    wr_ptr_d     = '0;
                    byte_idx_d   = '0;
                    word_buf_d   = '0;
                    valid_d      = '0;
                    load_count_d = '0;
                    csum_d       = '0;
                    err_d        = 1'b0;
                end
            end
`endif

            StRun: begin
                if (reload) begin
                    // Old memory contents stay but are masked by the cleared valid bits.
                    state_d      = StLoad;
                    wr_ptr_d     = '0;
                    byte_idx_d   = '0;
                    word_buf_d   = '0;
                    valid_d      = '0;
                    load_count_d = '0;
`ifdef PROG_LOAD_CHECKSUM_EN
                    csum_d       = '0;
                    err_d        = 1'b0;
`endif
                end else begin
                    instr_d   = fetch_word;
                    i_valid_d = 1'b1;
                end
            end

            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= StLoad;
            wr_ptr_q     <= '0;
            byte_idx_q   <= '0;
            word_buf_q   <= '0;
            valid_q      <= '0;
            load_count_q <= '0;
            instr_q      <= DEFAULT_INSTR;
            i_valid_q    <= 1'b0;
`ifdef PROG_LOAD_CHECKSUM_EN
            csum_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            byte_idx_q   <= byte_idx_d;
            word_buf_q   <= word_buf_d;
            valid_q      <= valid_d;
            load_count_q <= load_count_d;
            instr_q      <= instr_d;
            i_valid_q    <= i_valid_d;
`ifdef PROG_LOAD_CHECKSUM_EN
            csum_q       <= csum_d;
            err_q        <= err_d;
`endif
        end
    end

    // Storage needs no reset: unwritten words are hidden by valid_q.
    always_ff @(posedge clk) begin
        if (n_reset && mem_we) begin
            mem[wr_ptr_q] <= new_word;
        end
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    assign ld_ready = (state_q == StLoad) || (state_q == StCheck);
    assign err      = err_q;
`else
    assign ld_ready = (state_q == StLoad);
    assign err      = 1'b0;
`endif
    assign cpu_en     = (state_q == StRun);
    assign I          = instr_q;
    assign i_valid    = i_valid_q;
    assign load_count = load_count_q;

endmodule
